// File: rtl/muldiv_pkg.sv
// muldiv_pkg: definitions shared by the multi-cycle multiply/divide unit.
//   - op encodings MD_MULT / MD_MULTU / MD_DIV / MD_DIVU (signed ops have op[0] == 0,
//     divide ops have op[1] == 1)
//   - FSM state enum md_state_t
//   - md_neg(): two's-complement negation on a wide vector; callers size-cast
//     in and out, so it serves any operand width up to MD_MAX_W bits.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Widest vector md_neg handles; the double-width product limits WIDTH to 64.
  localparam int MD_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic [MD_MAX_W-1:0] md_neg(input logic [MD_MAX_W-1:0] x);
    return ~x + MD_MAX_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step.
//   rem_i     (WIDTH+1) partial remainder from the previous step
//   bit_i     next dividend bit, MSB first
//   divisor_i (WIDTH)   divisor magnitude
//   rem_o     (WIDTH+1) new partial remainder
//   q_o       quotient bit produced by this step
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvx;

  // One extra bit of headroom so the shifted remainder never wraps before
  // the compare; the remainder itself always fits back into WIDTH+1 bits.
  assign shifted = {rem_i, bit_i};
  assign dvx     = {2'b00, divisor_i};
  assign q_o     = (shifted >= dvx);
  assign rem_o   = RW'(q_o ? (shifted - dvx) : shifted);

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage, one bit
// per cycle (shift-add multiply, restoring divide on operand magnitudes with
// sign fix-up at the end).
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start_i         request, held by EX until done_o
//   op_i            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa_i / opb_i   multiplicand/dividend, multiplier/divisor
//   annul_i         flush: drop the current operation, back to IDLE
//   stall_o         pipeline hold (combinational)
//   done_o          result valid (state DONE)
//   hi_o / lo_o     product high/low, or remainder/quotient (registered)
//   div_zero_o      last divide had a zero divisor
//   state_dbg       current FSM state (md_state_t encoding)
// Handshake: start_i acts as a level-held valid; done_o is the completion
// strobe. The unit returns to IDLE only after start_i drops in DONE, so a
// request left high in DONE never retriggers.
// Build option: define MULDIV_DIV_EN to compile in the divider and
// div_zero_o; without it DIV/DIVU finish at once with zero results.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o,
  output logic [1:0]       state_dbg
);

  localparam int W2 = 2 * WIDTH;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    acc;      // mult: {partial product, multiplier}; div: quotient in low half
  logic [WIDTH-1:0] opx_q;    // multiplicand (mult) or divisor (div) magnitude
  logic             neg_a, neg_b;
  logic             go, last, sgn, div_short, dz_set;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    acc_nxt, fin;

  assign go   = start_i & ~annul_i;   // annul wins over start
  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign sgn  = ~op_i[0];

  assign mag_a = (sgn & opa_i[WIDTH-1]) ? WIDTH'(md_neg(MD_MAX_W'(opa_i))) : opa_i;
  assign mag_b = (sgn & opb_i[WIDTH-1]) ? WIDTH'(md_neg(MD_MAX_W'(opb_i))) : opb_i;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_q, rem_new;
  logic             q_bit, div_q;
  logic [WIDTH-1:0] quo_c, rem_c;

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (acc[WIDTH-1]),
    .divisor_i (opx_q),
    .rem_o     (rem_new),
    .q_o       (q_bit)
  );

  assign div_short = op_i[1] & (opb_i == '0);
  assign dz_set    = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= 1'b0;
    end else if (state == IDLE && go) begin
      rem_q <= '0;
      div_q <= op_i[1];
    end else if (state == CALC && !annul_i) begin
      rem_q <= rem_new;
    end
  end
`else
  // Without the divider every divide request completes immediately.
  assign div_short = op_i[1];
  assign dz_set    = 1'b0;
`endif

  // Next accumulator and sign-corrected final result.
  always_comb begin
    mul_sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opx_q} : '0);
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    fin     = (neg_a ^ neg_b) ? W2'(md_neg(MD_MAX_W'(acc_nxt))) : acc_nxt;
`ifdef MULDIV_DIV_EN
    quo_c = {acc[WIDTH-2:0], q_bit};
    rem_c = rem_new[WIDTH-1:0];
    if (div_q) begin
      acc_nxt = {acc[W2-1:WIDTH], quo_c};
      // Remainder follows the dividend's sign, quotient the sign product.
      fin = {neg_a ? WIDTH'(md_neg(MD_MAX_W'(rem_c))) : rem_c,
             (neg_a ^ neg_b) ? WIDTH'(md_neg(MD_MAX_W'(quo_c))) : quo_c};
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = div_short ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (!start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul_i) state_nxt = IDLE;
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      opx_q      <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            cnt   <= '0;
            neg_a <= sgn & opa_i[WIDTH-1];
            neg_b <= sgn & opb_i[WIDTH-1];
            if (op_i[1]) begin
              opx_q <= mag_b;
              acc   <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opx_q <= mag_a;
              acc   <= {{WIDTH{1'b0}}, mag_b};
            end
            if (div_short) begin
              hi_o       <= '0;
              lo_o       <= '0;
              div_zero_o <= dz_set;
            end
          end
        end
        CALC: begin
          if (!annul_i) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_nxt;
            if (last) begin
              hi_o       <= fin[W2-1:WIDTH];
              lo_o       <= fin[WIDTH-1:0];
              div_zero_o <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o   = start_i & (state != DONE) & ~annul_i;
  assign done_o    = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed test of ex_muldiv (WIDTH=32). A driver task issues
// each operation and pushes its hand-computed {div_zero, hi, lo} onto exp_q;
// a monitor pops and compares on every rising edge of done_o.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk, rst, start_i, annul_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i, opb_i;
  logic          stall_o, done_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;
  logic [1:0]    state_dbg;

  logic [64:0]   exp_q[$];
  logic [64:0]   last_exp;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          done_prev = 1'b0;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .annul_i    (annul_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] mk(input logic dz, input logic [31:0] hi, input logic [31:0] lo);
    return {dz, hi, lo};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done_o && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got %h expected no completion", {div_zero_o, hi_o, lo_o});
      end else begin
        check("result", {div_zero_o, hi_o, lo_o}, exp_q.pop_front());
      end
    end
    done_prev = done_o;
  end

  // driver: issue one op, check latency/stall/hold, then drop start
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [64:0] exp, input int exp_lat);
    int lat;
    bit stall_ok;
    @(negedge clk);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    exp_q.push_back(exp);
    last_exp = exp;
    #1;
    stall_ok = stall_o;
    lat = 0;
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        opa_i = $urandom;   // operands must be ignored after sampling
        opb_i = $urandom;
      end
      if (!done_o && !stall_o) stall_ok = 1'b0;
    end
    check({name, "_latency"}, 65'(lat), 65'(exp_lat));
    check({name, "_stall_busy"}, 65'(stall_ok), 65'(1));
    check({name, "_stall_done"}, 65'(stall_o), 65'(0));
    repeat (2) @(negedge clk);
    check({name, "_done_hold"}, 65'(done_o), 65'(1));
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_back_idle"}, 65'(state_dbg), 65'(IDLE));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {div_zero_o, hi_o, lo_o}, 65'(0));
    check("reset_done", 65'(done_o), 65'(0));
    check("reset_state", 65'(state_dbg), 65'(IDLE));
    check("reset_stall", 65'(stall_o), 65'(0));
    rst = 1'b0;

    run_op("multu_ff", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(1'b0, 32'hFFFFFFFE, 32'h00000001), 33);
    run_op("mult_n3x7", MD_MULT, 32'hFFFFFFFD, 32'd7, mk(1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB), 33);
    run_op("mult_minsq", MD_MULT, 32'h80000000, 32'h80000000, mk(1'b0, 32'h40000000, 32'h0), 33);
    run_op("mult_0xn5", MD_MULT, 32'h0, 32'hFFFFFFFB, mk(1'b0, 32'h0, 32'h0), 33);
    run_op("div_n7d2", MD_DIV, 32'hFFFFFFF9, 32'd2,
           DIV_EN ? mk(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD) : mk(1'b0, 32'h0, 32'h0), DIV_EN ? 33 : 1);
    run_op("divu_100d7", MD_DIVU, 32'd100, 32'd7,
           DIV_EN ? mk(1'b0, 32'd2, 32'd14) : mk(1'b0, 32'h0, 32'h0), DIV_EN ? 33 : 1);
    run_op("div_mindn1", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
           DIV_EN ? mk(1'b0, 32'h0, 32'h80000000) : mk(1'b0, 32'h0, 32'h0), DIV_EN ? 33 : 1);
    run_op("div_7dn2", MD_DIV, 32'd7, 32'hFFFFFFFE,
           DIV_EN ? mk(1'b0, 32'd1, 32'hFFFFFFFD) : mk(1'b0, 32'h0, 32'h0), DIV_EN ? 33 : 1);
    run_op("div_9d3", MD_DIV, 32'd9, 32'd3,
           DIV_EN ? mk(1'b0, 32'd0, 32'd3) : mk(1'b0, 32'h0, 32'h0), DIV_EN ? 33 : 1);
    run_op("divu_5d0", MD_DIVU, 32'd5, 32'd0, mk(DIV_EN, 32'h0, 32'h0), 1);
    run_op("multu_2x3", MD_MULTU, 32'd2, 32'd3, mk(1'b0, 32'h0, 32'd6), 33);

    // annul pulsed during cycle 10 of a MULT
    @(negedge clk);
    op_i = MD_MULT; opa_i = 32'd11; opb_i = 32'd13; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    check("annul_stall", 65'(stall_o), 65'(0));
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    check("annul_idle", 65'(state_dbg), 65'(IDLE));
    repeat (3) @(negedge clk);
    check("annul_no_done", 65'(done_o), 65'(0));
    check("annul_hold", {div_zero_o, hi_o, lo_o}, last_exp);
    run_op("mult_5xn6", MD_MULT, 32'd5, 32'hFFFFFFFA, mk(1'b0, 32'hFFFFFFFF, 32'hFFFFFFE2), 33);

    // reset asserted at cycle 5 of an in-flight op
    @(negedge clk);
    op_i = DIV_EN ? MD_DIV : MD_MULT; opa_i = 32'hFFFFFF9C; opb_i = 32'd3; start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {div_zero_o, hi_o, lo_o}, 65'(0));
    check("midrst_done", 65'(done_o), 65'(0));
    check("midrst_state", 65'(state_dbg), 65'(IDLE));
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("multu_3x4", MD_MULTU, 32'd3, 32'd4, mk(1'b0, 32'h0, 32'd12), 33);

    repeat (2) @(negedge clk);
    check("queue_empty", 65'(exp_q.size()), 65'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
